// File: rtl/aqua_lcd_ctrl.sv
// HD44780-style LCD bus sequencer: runs the power-on init bytes itself, then
// turns host command/data writes into setup / EN pulse / hold / execution-wait timing.
module aqua_lcd_ctrl #(
  parameter int INIT_WAIT_CYC = 750000,
  parameter int SETUP_CYC     = 2,
  parameter int EN_CYC        = 12,
  parameter int HOLD_CYC      = 2,
  parameter int WAIT_CYC      = 1850,
  parameter int CLR_WAIT_CYC  = 76000
) (
  input  logic       clk_i,
  input  logic       rst_n,
  input  logic       i_valid,
  output logic       o_ready,
  input  logic       i_rs,
  input  logic [7:0] i_data,
  output logic       o_init_done,
  output logic       o_lcd_on,
  output logic       o_lcd_en,
  output logic       o_lcd_rs,
  output logic       o_lcd_rw,
  output logic [7:0] o_lcd_data
);

  // state       | meaning
  // S_INIT_WAIT | power-up delay before the first init byte
  // S_SETUP     | RS/DATA driven, EN low
  // S_PULSE     | EN high
  // S_HOLD      | EN low, RS/DATA still held
  // S_EXEC_WAIT | controller busy executing the byte
  // S_IDLE      | ready for a host write
  // INIT_LOAD has no residency: it is the edge that latches the next init byte and enters S_SETUP.
  typedef enum logic [2:0] {
    S_INIT_WAIT,
    S_SETUP,
    S_PULSE,
    S_HOLD,
    S_EXEC_WAIT,
    S_IDLE
  } state_t;

  localparam int MAX_A   = (INIT_WAIT_CYC > SETUP_CYC) ? INIT_WAIT_CYC : SETUP_CYC;
  localparam int MAX_B   = (EN_CYC > HOLD_CYC) ? EN_CYC : HOLD_CYC;
  localparam int MAX_C   = (WAIT_CYC > CLR_WAIT_CYC) ? WAIT_CYC : CLR_WAIT_CYC;
  localparam int MAX_AB  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int MAX_CYC = (MAX_AB > MAX_C) ? MAX_AB : MAX_C;
  localparam int CW      = $clog2(MAX_CYC + 1);

  localparam logic [CW-1:0] LD_INIT  = CW'(INIT_WAIT_CYC - 1);
  localparam logic [CW-1:0] LD_SETUP = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] LD_EN    = CW'(EN_CYC - 1);
  localparam logic [CW-1:0] LD_HOLD  = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] LD_WAIT  = CW'(WAIT_CYC - 1);
  localparam logic [CW-1:0] LD_CLR   = CW'(CLR_WAIT_CYC - 1);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            rs_q;
  logic [7:0]      data_q;
  logic [2:0]      idx_q;
  logic            done_q;
  logic            en_q;
  logic            on_q;
  logic            latch_init;
  logic            accept;
  logic            set_done;
  logic            is_clr;
  logic            cnt_zero;

  function automatic logic [7:0] init_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    return 8'h38;
      2'd1:    return 8'h0C;
      2'd2:    return 8'h01;
      default: return 8'h06;
    endcase
  endfunction

  // Clear and home take far longer to execute inside the LCD controller.
  assign is_clr   = !rs_q && ((data_q == 8'h01) || (data_q == 8'h02));
  assign cnt_zero = (cnt_q == '0);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_zero ? cnt_q : cnt_q - 1'b1;
    latch_init = 1'b0;
    accept     = 1'b0;
    set_done   = 1'b0;
    case (state_q)
      S_INIT_WAIT: begin
        if (cnt_zero) begin
          latch_init = 1'b1;
          state_d    = S_SETUP;
          cnt_d      = LD_SETUP;
        end
      end
      S_SETUP: begin
        if (cnt_zero) begin
          state_d = S_PULSE;
          cnt_d   = LD_EN;
        end
      end
      S_PULSE: begin
        if (cnt_zero) begin
          state_d = S_HOLD;
          cnt_d   = LD_HOLD;
        end
      end
      S_HOLD: begin
        if (cnt_zero) begin
          state_d = S_EXEC_WAIT;
          cnt_d   = is_clr ? LD_CLR : LD_WAIT;
        end
      end
      S_EXEC_WAIT: begin
        if (cnt_zero) begin
          if (done_q) begin
            state_d = S_IDLE;
          end else if (idx_q == 3'd4) begin
            set_done = 1'b1;
            state_d  = S_IDLE;
          end else begin
            latch_init = 1'b1;
            state_d    = S_SETUP;
            cnt_d      = LD_SETUP;
          end
        end
      end
      S_IDLE: begin
        if (i_valid) begin
          accept  = 1'b1;
          state_d = S_SETUP;
          cnt_d   = LD_SETUP;
        end
      end
      default: begin
        state_d = S_INIT_WAIT;
        cnt_d   = LD_INIT;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_INIT_WAIT;
      cnt_q   <= LD_INIT;
      rs_q    <= 1'b0;
      data_q  <= 8'h00;
      idx_q   <= 3'd0;
      done_q  <= 1'b0;
      en_q    <= 1'b0;
      on_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      en_q    <= (state_d == S_PULSE);
      on_q    <= 1'b1;
      if (latch_init) begin
        rs_q   <= 1'b0;
        data_q <= init_byte(idx_q[1:0]);
        idx_q  <= idx_q + 3'd1;
      end else if (accept) begin
        rs_q   <= i_rs;
        data_q <= i_data;
      end
      if (set_done) begin
        done_q <= 1'b1;
      end
    end
  end

  assign o_ready     = (state_q == S_IDLE);
  assign o_init_done = done_q;
  assign o_lcd_on    = on_q;
  assign o_lcd_en    = en_q;
  assign o_lcd_rs    = rs_q;
  assign o_lcd_rw    = 1'b0;
  assign o_lcd_data  = data_q;

endmodule

// File: tb/tb_aqua_lcd_ctrl.sv
// Randomized bench for aqua_lcd_ctrl: a transfer-level timeline model predicts every
// output each cycle; directed writes cover clear timing, back-to-back and mid-pulse reset.
module tb_aqua_lcd_ctrl;

  localparam int P_INIT  = 10;
  localparam int P_SETUP = 2;
  localparam int P_EN    = 3;
  localparam int P_HOLD  = 2;
  localparam int P_WAIT  = 5;
  localparam int P_CLR   = 20;

  logic       clk_i = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_valid = 1'b0;
  logic       i_rs = 1'b0;
  logic [7:0] i_data = 8'h00;
  logic       o_ready, o_init_done, o_lcd_on, o_lcd_en, o_lcd_rs, o_lcd_rw;
  logic [7:0] o_lcd_data;

  aqua_lcd_ctrl #(
    .INIT_WAIT_CYC(P_INIT), .SETUP_CYC(P_SETUP), .EN_CYC(P_EN),
    .HOLD_CYC(P_HOLD), .WAIT_CYC(P_WAIT), .CLR_WAIT_CYC(P_CLR)
  ) dut (
    .clk_i(clk_i), .rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_rs(i_rs), .i_data(i_data), .o_init_done(o_init_done), .o_lcd_on(o_lcd_on),
    .o_lcd_en(o_lcd_en), .o_lcd_rs(o_lcd_rs), .o_lcd_rw(o_lcd_rw), .o_lcd_data(o_lcd_data)
  );

  always #5 clk_i = ~clk_i;

  int n_chk = 0;
  int n_err = 0;

  // Model: a timeline of transfers, each occupying [start, start+len) edges.
  int         m_n;
  bit         m_started;
  int         m_a, m_len, m_init_cnt;
  bit         m_done, m_ready_prev, m_acc;
  logic       m_rs;
  logic [7:0] m_data;
  logic [7:0] init_seq[4] = '{8'h38, 8'h0C, 8'h01, 8'h06};
  bit         seen_ready, en_prev;
  int         first_ready, init_pulses;
  logic [8:0] dq[$];

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, m_n);
    end
  endtask

  function automatic int xfer_len(input logic rs, input logic [7:0] d);
    return P_SETUP + P_EN + P_HOLD + ((!rs && (d == 8'h01 || d == 8'h02)) ? P_CLR : P_WAIT);
  endfunction

  function automatic bit model_en();
    return m_started && (m_n - m_a) >= P_SETUP && (m_n - m_a) < P_SETUP + P_EN;
  endfunction

  task automatic model_reset();
    m_n = 0; m_started = 0; m_a = 0; m_len = 0; m_init_cnt = 0;
    m_done = 0; m_ready_prev = 0; m_acc = 0; m_rs = 0; m_data = 8'h00;
    seen_ready = 0; en_prev = 0; first_ready = -1; init_pulses = 0;
  endtask

  task automatic model_start(input logic rs, input logic [7:0] d);
    m_a = m_n; m_rs = rs; m_data = d; m_len = xfer_len(rs, d); m_started = 1;
  endtask

  task automatic model_edge();
    logic       v, r;
    logic [7:0] d;
    v = i_valid; r = i_rs; d = i_data;
    m_n++;
    m_acc = 0;
    if (!m_started) begin
      if (m_n == P_INIT) begin
        model_start(1'b0, init_seq[0]);
        m_init_cnt = 1;
      end
    end else if (m_n == m_a + m_len && m_init_cnt < 4) begin
      model_start(1'b0, init_seq[m_init_cnt]);
      m_init_cnt++;
    end else if (m_n == m_a + m_len && !m_done) begin
      m_done = 1;
    end else if (m_ready_prev && v) begin
      model_start(r, d);
      m_acc = 1;
    end
  endtask

  task automatic check_all();
    bit ready_exp;
    ready_exp = m_done && (m_n >= m_a + m_len);
    chk_val("ready", 32'(o_ready), 32'(ready_exp));
    chk_val("en", 32'(o_lcd_en), 32'(model_en()));
    chk_val("rs", 32'(o_lcd_rs), 32'(m_rs));
    chk_val("data", 32'(o_lcd_data), 32'(m_data));
    chk_val("init_done", 32'(o_init_done), 32'(m_done));
    chk_val("lcd_on", 32'(o_lcd_on), 32'(m_n >= 1));
    chk_val("rw", 32'(o_lcd_rw), 32'd0);
    m_ready_prev = ready_exp;
    if (o_ready && !seen_ready) begin
      seen_ready  = 1;
      first_ready = m_n;
    end
    if (o_lcd_en && !en_prev && !o_init_done) init_pulses++;
    en_prev = o_lcd_en;
  endtask

  task automatic step();
    @(posedge clk_i);
    model_edge();
    @(negedge clk_i);
    check_all();
  endtask

  task automatic drive_next(input bit force_req);
    if (m_acc) i_valid = 1'b0;
    if (!i_valid) begin
      if (force_req || dq.size() > 0 || $urandom_range(0, 3) == 0) begin
        i_valid = 1'b1;
        if (dq.size() > 0) begin
          {i_rs, i_data} = dq.pop_front();
        end else begin
          i_rs = 1'($urandom_range(0, 1));
          case ($urandom_range(0, 3))
            0:       i_data = 8'h01;
            1:       i_data = 8'h02;
            default: i_data = 8'($urandom);
          endcase
        end
      end else begin
        i_rs   = 1'($urandom);
        i_data = 8'($urandom);
      end
    end
  endtask

  initial begin
    bit found;
    model_reset();
    repeat (2) @(negedge clk_i);
    check_all();
    // Request raised during init; must wait for the first IDLE cycle.
    i_valid = 1'b1; i_rs = 1'b1; i_data = 8'h55;
    dq.push_back({1'b1, 8'h41});
    dq.push_back({1'b0, 8'h01});
    dq.push_back({1'b1, 8'h01});
    dq.push_back({1'b0, 8'h02});
    dq.push_back({1'b1, 8'h48});
    dq.push_back({1'b1, 8'h49});
    rst_n = 1'b1;
    check_all();
    for (int k = 0; k < 600; k++) begin
      step();
      drive_next(1'b0);
    end
    chk_val("init_ready_cycle", 32'(first_ready), 32'd73);
    chk_val("init_pulse_count", 32'(init_pulses), 32'd4);

    // Reset in the middle of an EN pulse.
    found = 0;
    for (int k = 0; k < 100 && !found; k++) begin
      step();
      drive_next(1'b1);
      if (model_en()) found = 1;
    end
    chk_val("pulse_found", 32'(found), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_val("rst_en", 32'(o_lcd_en), 32'd0);
    chk_val("rst_done", 32'(o_init_done), 32'd0);
    chk_val("rst_ready", 32'(o_ready), 32'd0);
    chk_val("rst_on", 32'(o_lcd_on), 32'd0);
    chk_val("rst_data", 32'(o_lcd_data), 32'd0);
    i_valid = 1'b0;
    model_reset();
    repeat (2) @(negedge clk_i);
    check_all();
    rst_n = 1'b1;
    for (int k = 0; k < 200; k++) begin
      step();
      drive_next(1'b0);
    end
    chk_val("replay_ready_cycle", 32'(first_ready), 32'd73);
    chk_val("replay_pulse_count", 32'(init_pulses), 32'd4);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
